// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first,
// carry rippled between chunks through a register.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW = (NCHUNK > 1) ? WIDTH - CHUNK : 1;

    generate
        if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]    part_q, part_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNK-1:0]    a_ck, b_ck, s_ck;
    logic                c_out, c_msb;
    logic [CHUNK+PW-1:0] part_ext;
    logic [WIDTH-1:0]    result;

    always_comb begin
        a_ck = a_q[CHUNK-1:0];
        b_ck = b_q[CHUNK-1:0];
        {c_out, s_ck} = {1'b0, a_ck} + {1'b0, b_ck} + {{CHUNK{1'b0}}, carry_q};
        // carry into the top bit of this chunk, recovered from the sum bit
        c_msb = s_ck[CHUNK-1] ^ a_ck[CHUNK-1] ^ b_ck[CHUNK-1];
        // finished chunks collect at the top and slide down one chunk per cycle
        part_ext = {s_ck, part_q};
        result = part_ext[CHUNK+PW-1 -: WIDTH];

        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        part_d = part_q;
        idx_d = idx_q;
        carry_d = carry_q;
        sum_d = sum_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        zero_d = zero_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d = a;
                    b_d = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    part_d = '0;
                    idx_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d = a_q >> CHUNK;
                b_d = b_q >> CHUNK;
                part_d = part_ext[CHUNK+PW-1 -: PW];
                carry_d = c_out;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NCHUNK - 1)) begin
                    sum_d = result;
                    cout_d = c_out;
                    ovf_d = c_out ^ c_msb;
                    zero_d = (result == '0);
                    idx_d = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            part_q <= '0;
            idx_q <= '0;
            carry_q <= 1'b0;
            sum_q <= '0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            part_q <= part_d;
            idx_q <= idx_d;
            carry_q <= carry_d;
            sum_q <= sum_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum = sum_q;
    assign cout = cout_q;
    assign ovf = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder (16/4) plus exhaustive 4/1 sweep.
module tb_chunk_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] sum;

    logic        start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [3:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic [3:0]  sum2;

    int tests = 0;
    int fails = 0;
    logic [15:0] prev = '0;

    always #5 clk = ~clk;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    chunk_serial_adder #(.WIDTH(4), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2),
        .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op, let the next edge accept it, then scramble the inputs.
    task automatic issue(input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic ci);
        sub = s; a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~x; b = ~y; sub = ~s; cin = ~ci;
        chk("busy_after_accept", {31'b0, busy}, 1);
    endtask

    task automatic finish_op(input string tag, input logic [15:0] es,
                             input logic ec, input logic ev, input logic ez);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk({tag, "_run_flags"}, {30'b0, busy, done}, 32'h2);
            chk({tag, "_run_hold"}, {16'b0, sum}, {16'b0, prev});
        end
        @(posedge clk); #1;
        chk({tag, "_done_flags"}, {30'b0, busy, done}, 32'h1);
        chk({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
        chk({tag, "_cvz"}, {29'b0, cout, ovf, zero}, {29'b0, ec, ev, ez});
        prev = es;
    endtask

    initial begin
        logic [3:0] bb;
        logic [4:0] full;
        logic [3:0] low;
        logic       c_in0, v_exp;

        #12;
        chk("reset_outs", {10'b0, busy, done, sum, cout, ovf, zero},
            32'h0);
        @(negedge clk); rst_n = 1'b1;

        @(negedge clk); issue(0, 16'h00FF, 16'h0001, 0);
        finish_op("add_00ff", 16'h0100, 0, 0, 0);
        @(posedge clk); #1;
        chk("done_pulse_end", {30'b0, busy, done}, 0);

        @(negedge clk); issue(0, 16'hFFFF, 16'h0001, 0);
        finish_op("add_wrap", 16'h0000, 1, 0, 1);
        @(negedge clk); issue(0, 16'h7FFF, 16'h0001, 0);
        finish_op("add_ovf", 16'h8000, 0, 1, 0);
        @(negedge clk); issue(1, 16'h0005, 16'h0007, 0);
        finish_op("sub_borrow", 16'hFFFE, 0, 0, 0);
        @(negedge clk); issue(1, 16'h8000, 16'h0001, 0);
        finish_op("sub_ovf", 16'h7FFF, 1, 1, 0);
        @(negedge clk); issue(0, 16'h1234, 16'h1111, 1);
        finish_op("add_cin", 16'h2346, 0, 0, 0);
        @(negedge clk); issue(1, 16'h0007, 16'h0007, 1);
        finish_op("sub_eq", 16'h0000, 1, 0, 1);

        // start re-pulsed mid-RUN must be ignored
        @(negedge clk); issue(0, 16'h0010, 16'h0020, 0);
        start = 1'b1; sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        chk("repulse_busy", {31'b0, busy}, 1);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("repulse_sum", {16'b0, sum}, 32'h0030);
        chk("repulse_done", {31'b0, done}, 1);
        prev = 16'h0030;

        // start held in DONE: back-to-back, no idle cycle
        sub = 0; a = 16'h0001; b = 16'h0002; cin = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {30'b0, busy, done}, 32'h2);
        finish_op("b2b", 16'h0003, 0, 0, 0);

        // async reset mid-RUN
        @(negedge clk); issue(0, 16'h1111, 16'h2222, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_outs", {10'b0, busy, done, sum, cout, ovf, zero},
            32'h0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        prev = 16'h0000;
        @(negedge clk); issue(0, 16'h0003, 16'h0004, 0);
        finish_op("after_rst", 16'h0007, 0, 0, 0);

        // exhaustive WIDTH=4 CHUNK=1
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int c = 0; c < 2; c++) begin
                        bb = (s == 1) ? ~4'(y) : 4'(y);
                        c_in0 = (s == 1) ? 1'b1 : 1'(c);
                        full = 5'(x) + 5'(bb) + 5'(c_in0);
                        low = {1'b0, 3'(x)} + {1'b0, bb[2:0]} + 4'(c_in0);
                        v_exp = low[3] ^ full[4];
                        @(negedge clk);
                        sub2 = 1'(s); a2 = 4'(x); b2 = 4'(y); cin2 = 1'(c);
                        start2 = 1'b1;
                        @(posedge clk); #1;
                        start2 = 1'b0;
                        repeat (4) @(posedge clk);
                        #1;
                        chk("exh_w4c1",
                            {24'b0, done2, sum2, cout2, v_exp ? ovf2 : ovf2,
                             zero2},
                            {24'b0, 1'b1, full[3:0], full[4], v_exp,
                             full[3:0] == 4'h0});
                    end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
